// File: rtl/egress_ctrl.sv
// Replays stored packets from DDR as an AXI4-Stream: reads the header beat, votes the
// triplicated length, then fetches the body in bursts that never cross a 4 KB boundary.
module egress_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   wr_ptr,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    tmr_err,
  output logic                    len_err,
  output logic                    rresp_err,
  output logic [31:0]             pkt_cnt,
  output logic [2:0]              fsm_state
);
  localparam int KW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_AR  = 3'd1,
    HDR_R   = 3'd2,
    BODY_AR = 3'd3,
    BODY_R  = 3'd4,
    ERR     = 3'd5
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] body_addr;
  logic [4:0]            body_rem;
  logic [4:0]            beat_left;
  logic [5:0]            len_rem;

  logic [15:0] l0, l1, l2, hdr_len;
  logic [4:0]  hdr_beats;
  logic        hdr_ok;
  logic [6:0]  to_bnd, burst;
  logic        r_fire;

  function automatic logic [KW-1:0] keep_mask(input logic [6:0] n);
    logic [KW-1:0] m;
    if (n == 7'd0 || int'(n) >= KW) m = '1;
    else m = ~({KW{1'b1}} << n);
    return m;
  endfunction

  always_comb begin
    l0        = m_axi_rdata[15:0];
    l1        = m_axi_rdata[31:16];
    l2        = m_axi_rdata[47:32];
    hdr_len   = (l0 & l1) | (l1 & l2) | (l0 & l2);
    hdr_ok    = (hdr_len >= 16'd60) && (hdr_len <= 16'd1514);
    hdr_beats = hdr_len[10:6] + {4'd0, |hdr_len[5:0]};
    // Beats left before the next 4 KB page; the body burst is clipped to this.
    to_bnd    = 7'd64 - {1'b0, body_addr[11:6]};
    burst     = ({2'b00, body_rem} < to_bnd) ? {2'b00, body_rem} : to_bnd;
  end

  // Valid/ready: a beat moves on any cycle where valid and ready are both high; a source
  // holds valid and payload stable until that cycle. R is only taken when the single
  // output register is free or draining this cycle, and always in ERR to flush the bus.
  assign m_axi_rready  = (state == ERR) ||
                         ((state == HDR_R || state == BODY_R) && (!m_axis_tvalid || m_axis_tready));
  assign r_fire        = m_axi_rvalid && m_axi_rready;
  assign m_axi_arid    = '0;
  assign m_axi_arsize  = 3'd6;
  assign m_axi_arburst = 2'b01;
  assign fsm_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_addr       <= BASE_ADDR;
      body_addr     <= BASE_ADDR;
      body_rem      <= '0;
      beat_left     <= '0;
      len_rem       <= '0;
      m_axi_araddr  <= BASE_ADDR;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      tmr_err       <= 1'b0;
      len_err       <= 1'b0;
      rresp_err     <= 1'b0;
      pkt_cnt       <= '0;
    end else begin
      tmr_err <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        if (m_axis_tlast) pkt_cnt <= pkt_cnt + 32'd1;
      end
      if (r_fire && m_axi_rresp != 2'b00) rresp_err <= 1'b1;

      case (state)
        IDLE: begin
          if (wr_ptr != rd_addr) begin
            state         <= HDR_AR;
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= rd_addr;
            m_axi_arlen   <= 8'd0;
          end
        end
        HDR_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            state         <= HDR_R;
          end
        end
        HDR_R: begin
          if (r_fire) begin
            tmr_err <= !((l0 == l1) && (l1 == l2));
            if (!hdr_ok) begin
              len_err <= 1'b1;
              state   <= ERR;
            end else begin
              m_axis_tdata  <= m_axi_rdata;
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= (hdr_beats == 5'd1);
              m_axis_tkeep  <= (hdr_beats == 5'd1) ? keep_mask(hdr_len[6:0]) : '1;
              len_rem       <= hdr_len[5:0];
              if (hdr_beats == 5'd1) begin
                rd_addr <= rd_addr + ADDR_WIDTH'(64);
                state   <= IDLE;
              end else begin
                body_addr <= rd_addr + ADDR_WIDTH'(64);
                body_rem  <= hdr_beats - 5'd1;
                beat_left <= hdr_beats - 5'd1;
                state     <= BODY_AR;
              end
            end
          end
        end
        BODY_AR: begin
          if (!m_axi_arvalid) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= body_addr;
            m_axi_arlen   <= 8'(burst - 7'd1);
          end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            body_addr     <= body_addr + ADDR_WIDTH'({burst, 6'b0});
            body_rem      <= body_rem - burst[4:0];
            state         <= BODY_R;
          end
        end
        BODY_R: begin
          if (r_fire) begin
            m_axis_tdata  <= m_axi_rdata;
            m_axis_tvalid <= 1'b1;
            beat_left     <= beat_left - 5'd1;
            if (beat_left == 5'd1) begin
              m_axis_tlast <= 1'b1;
              m_axis_tkeep <= keep_mask({1'b0, len_rem});
              // All bursts are issued by now, so body_addr already points past the packet.
              rd_addr      <= body_addr;
            end else begin
              m_axis_tlast <= 1'b0;
              m_axis_tkeep <= '1;
            end
            if (m_axi_rlast) state <= (body_rem == 5'd0) ? IDLE : BODY_AR;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/egress_ctrl.md
# egress_ctrl

Reads packets that the ingress stage stored in DDR back out over AXI4 read bursts and replays them as an AXI4-Stream toward the downstream consumer. Each stored packet starts on a 64-byte-aligned address with a header beat carrying a triplicated 16-bit length and the FEP header. The block majority-votes the length, fetches the packet in bursts that never cross a 4 KB boundary, and emits it with correct `tkeep`/`tlast`. It sits directly downstream of the DDR write path and consumes the memory image that stage produces.

## Interface
- `ADDR_WIDTH`, 32, AXI address width
- `DATA_WIDTH`, 512, AXI/AXIS data width (64-byte beat)
- `ID_WIDTH`, 4, AXI ID width
- `BASE_ADDR`, 0, DDR byte address of the first packet
- `clk`  in  1  single clock
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `wr_ptr`  in  ADDR_WIDTH  byte address one past the last fully written packet; 64-aligned, monotonic modulo 2^ADDR_WIDTH
- `m_axi_arid`/`araddr`/`arlen`/`arsize`/`arburst`  out  ID/ADDR/8/3/2  read address; `arid`=0, `arsize`=6, `arburst`=INCR
- `m_axi_arvalid` out 1, `m_axi_arready` in 1
- `m_axi_rdata` in DATA_WIDTH, `m_axi_rresp` in 2, `m_axi_rlast` in 1, `m_axi_rvalid` in 1, `m_axi_rready` out 1
- `m_axis_tdata` out DATA_WIDTH, `m_axis_tkeep` out DATA_WIDTH/8, `m_axis_tlast` out 1, `m_axis_tvalid` out 1, `m_axis_tready` in 1
- `tmr_err`  out  1  one-cycle pulse when the three length copies disagree
- `len_err`  out  1  sticky; voted length is out of range
- `rresp_err`  out  1  sticky; any `rresp` != OKAY
- `pkt_cnt`  out  32  packets fully emitted, wraps

## Operation
- Header beat layout: bits [15:0], [31:16], [47:32] hold length copies L0/L1/L2; bits [95:48] hold the FEP header 0x1eadfeb5ac0d; bits above 95 hold frame bytes.
- Voted length: `L = (L0&L1)|(L1&L2)|(L0&L2)`, computed bitwise. `tmr_err` pulses if L0, L1 and L2 are not all equal.
- Valid length range is 60..1514. Beat count is `B = ceil(L/64)`, in the range 1..24.
- `rd_addr` resets to `BASE_ADDR`. After the last beat of a packet is accepted, `rd_addr += B*64`, with wrap modulo 2^ADDR_WIDTH.
- Output register is a single stage. `m_axi_rready = !m_axis_tvalid || m_axis_tready`. Every R beat is loaded into the output register; none bypasses it.
- FSM:
  - IDLE: if `wr_ptr != rd_addr`, go to HDR_AR.
  - HDR_AR: `arvalid=1`, `araddr=rd_addr`, `arlen=0`. Hold until `arready`, then go to HDR_R.
  - HDR_R: on the R handshake, vote the length.
    - If L is out of range, set `len_err` and go to ERR. Nothing is emitted.
    - Otherwise load the beat with `tkeep` = all-ones, or the low `L` bits when B=1, and `tlast=(B==1)`.
    - Next state is IDLE if B=1, else BODY_AR.
  - BODY_AR: read the remaining B-1 beats from `rd_addr+64`. If the range crosses a 4 KB boundary, issue the first burst up to the boundary, then a second burst. Issue one AR at a time.
  - BODY_R: forward beats. The final beat has `tlast=1` and `tkeep` = low `(L mod 64)` bytes, or all-ones if the remainder is 0. On `rlast` of the final burst go to IDLE; otherwise go to BODY_AR for the second burst.
  - ERR: terminal state, left only by reset. Issues no AR and drives `rready=1`.
- `rresp` != OKAY sets `rresp_err`; the data is still forwarded.
- `pkt_cnt` increments on the AXIS handshake with `tlast=1`.

## Timing
- Reset values: `arvalid`, `tvalid`, `tlast`, `tmr_err`, `len_err`, `rresp_err` are 0; `pkt_cnt` is 0; `araddr` is `BASE_ADDR`; `arlen` is 0; `tdata` and `tkeep` are 0.
- `arvalid` rises the cycle after IDLE sees `wr_ptr != rd_addr`. AR fields are stable while `arvalid` is high and not ready.
- The header R beat reaches `m_axis_tvalid` one cycle after the R handshake. Body beats also take one cycle, so the block sustains 1 beat/cycle when `tready=1`.
- `tmr_err` asserts the cycle after the header R handshake.
- Reset mid-burst abandons the outstanding AR/R immediately. The system must also reset the AXI slave.
- `wr_ptr == rd_addr` means empty. The block never reads beyond `wr_ptr`.

## Test plan
- 60-byte packet at 0x0, L0=L1=L2=60, `wr_ptr`=0x40 -> one AR (addr 0x0, len 0); one AXIS beat with `tlast=1`, `tkeep`=2^60-1; `pkt_cnt`=1; `rd_addr`=0x40.
- 130-byte packet followed by a 64-byte packet -> ARs (0x0,len0), (0x40,len1), (0xC0,len0); AXIS beats 3+1; the third beat has `tkeep`=0x3; `pkt_cnt`=2.
- Length copies L1=0x0200, L0=L2=0x0100 -> L=256; `tmr_err` pulses once; 4 beats emitted; the last beat has full `tkeep`.
- Packet at 0xFC0, L=200 -> ARs (0xFC0,len0), then the body is split at 0x1000: (0x1000,len2); 4 beats total.
- Random `tready` low 50% and random `rvalid` gaps on a 1514-byte packet -> all 24 beats in order, no drop or duplicate; data is held stable while `tvalid && !tready`.
- Voted L=2000 -> `len_err`=1, no AXIS beat, no further AR; `rst_n` pulse clears the error and restarts at `BASE_ADDR`.
